unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port and data port.
//  Grants one requester at a time and drives the memory for MEM_LAT cycles.
//  Returns read data with a one-cycle ready pulse.
//  Fetch and load/store stages stall on their req until their rdy pulses.
// PARAMETERS
//  ADDR_W   16  address width (word addressed)
//  DATA_W   16  data width
//  MEM_LAT  4   memory access cycles; legal range >=1; counter width $clog2(MEM_LAT+1)
// PORTS
//  clk        in   1       clock; all logic on posedge
//  rst        in   1       synchronous reset, active-high
//  i_req      in   1       fetch read request; held until i_rdy
//  i_addr     in   ADDR_W  fetch address
//  i_rdy      out  1       one-cycle pulse: fetch complete
//  i_data     out  DATA_W  fetched word; valid on i_rdy, held until next fetch completion
//  d_re       in   1       data read request; held until d_rdy
//  d_we       in   1       data write request; held until d_rdy
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_rdy      out  1       one-cycle pulse: load/store complete
//  d_rdata    out  DATA_W  load data; valid on d_rdy (reads only), held otherwise
//  mem_re     out  1       memory read enable, held for the full access
//  mem_we     out  1       memory write enable, held for the full access
//  mem_addr   out  ADDR_W  memory address, stable for the full access
//  mem_wdata  out  DATA_W  memory write data, stable for the full access
//  mem_rdata  in   DATA_W  memory read data; valid in the last access cycle
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset values (rst high at an edge):
//   - all outputs 0; state=IDLE; last_grant=INSTR; counter=0
//  States and transitions:
//   - IDLE: sample requests at the edge
//       * none pending -> stay in IDLE
//       * one pending -> grant it
//       * both pending -> grant the one NOT in last_grant; first grant after reset goes to data
//       * on grant: capture addr, wdata and op into registers; set last_grant; go to ACCESS
//   - ACCESS: mem_* driven from the captured registers for exactly MEM_LAT cycles; counter = MEM_LAT-1 down to 0
//       * at the edge ending the cycle with counter==0: register mem_rdata into i_data or d_rdata (reads only); go to RESP
//   - RESP: lasts one cycle
//       * mem_re=mem_we=0
//       * i_rdy or d_rdy =1 for the granted port only
//       * new requests are not sampled; next state IDLE
//  Latency and throughput:
//   - request sampled in IDLE at cycle T -> mem active T+1..T+MEM_LAT -> rdy in cycle T+MEM_LAT+1
//   - back-to-back accesses: one per MEM_LAT+2 cycles
//  Request rules:
//   - d_re and d_we both high is treated as a write; d_rdata is not updated
//   - address/data changes after grant are ignored (values are captured)
//   - req dropped mid-access: the access still completes and rdy still pulses
//   - a write that is dropped mid-access is still written
//  Reset mid-access: the next state is IDLE with mem_re/we=0 and no rdy pulse; the partial write is not retried.
//  i_rdy and d_rdy are never high in the same cycle; mem_re and mem_we are never both high.
// TESTING (MEM_LAT=4 unless stated)
//  1. i_req with i_addr=0x0010 sampled at cycle 1; mem_rdata=0xABCD in cycle 5 -> mem_re=1 in cycles 2-5 with mem_addr=0x0010; i_rdy=1 in cycle 6 with i_data=0xABCD.
//  2. i_req and d_re (d_addr=0x0020) both high right after reset at cycle T -> data served first: d_rdy at T+5; instruction sampled at T+6, mem_re in T+7..T+10, i_rdy at T+11.
//  3. d_we with d_addr=0x0040, d_wdata=0x1234 -> mem_we=1 for 4 cycles with address/data stable; one d_rdy pulse; d_rdata unchanged; i_rdy stays 0.
//  4. i_req and d_re held high for 30 cycles -> grants alternate D,I,D,I,D at 6-cycle spacing; no starvation.
//  5. rst asserted in the 2nd ACCESS cycle of a write -> next cycle all outputs are 0 and no rdy pulse; a fresh i_req then completes normally.
//  6. MEM_LAT=1, single d_re -> mem_re for 1 cycle, d_rdy 2 cycles after sampling; both edges of the counter are covered.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port fixed-latency memory between instruction fetch and data ports.
// Latency: request sampled in IDLE at cycle T -> memory active T+1..T+MEM_LAT -> rdy pulse at T+MEM_LAT+1.
// Backpressure: requesters hold req until their rdy pulse; one access per MEM_LAT+2 cycles, alternating on contention.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rdy,
    output logic [DATA_W-1:0] i_data,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rdy,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_last_d;   // last grant went to the data port
    logic              r_gnt_d;    // current access belongs to the data port
    logic              r_op_we;    // current access is a write
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_i_data;
    logic [DATA_W-1:0] r_d_data;

    logic              w_d_pend;
    logic              w_grant;
    logic              w_grant_d;
    logic              w_cnt_zero;

    // Data wins when it is alone or when instruction fetch had the previous grant.
    assign w_d_pend   = d_re | d_we;
    assign w_grant    = i_req | w_d_pend;
    assign w_grant_d  = w_d_pend & (~i_req | ~r_last_d);
    assign w_cnt_zero = (r_cnt == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: RESP never samples requests, so it always returns to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_grant)    w_next = S_ACCESS;
            S_ACCESS: if (w_cnt_zero) w_next = S_RESP;
            S_RESP:                   w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    // Grant capture, access countdown and read-data return registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b0;
            r_gnt_d  <= 1'b0;
            r_op_we  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_i_data <= '0;
            r_d_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_gnt_d  <= w_grant_d;
                        r_last_d <= w_grant_d;
                        // Read+write together is a write.
                        r_op_we  <= w_grant_d & d_we;
                        r_addr   <= w_grant_d ? d_addr : i_addr;
                        r_wdata  <= w_grant_d ? d_wdata : '0;
                        r_cnt    <= CNT_W'(MEM_LAT - 1);
                    end
                end
                S_ACCESS: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!r_op_we) begin
                        // mem_rdata is only valid in the final access cycle.
                        if (r_gnt_d) r_d_data <= mem_rdata;
                        else         r_i_data <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state; memory bus is idle (all zero) outside ACCESS.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_rdy     = 1'b0;
        d_rdy     = 1'b0;
        case (r_state)
            S_ACCESS: begin
                mem_re    = ~r_op_we;
                mem_we    = r_op_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
            end
            S_RESP: begin
                i_rdy = ~r_gnt_d;
                d_rdy = r_gnt_d;
            end
            default: begin
            end
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign i_data  = r_i_data;
    assign d_rdata = r_d_data;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: MEM_LAT=4 instance with a scoreboard of expected rdy pulses,
// plus a MEM_LAT=1 instance for the minimum-latency corner.
// Memory model returns valid read data only in the last access cycle and logs every write cycle.
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // MEM_LAT=4 instance
    logic        i_req, i_rdy, d_re, d_we, d_rdy, mem_re, mem_we, busy;
    logic [15:0] i_addr, i_data, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    // MEM_LAT=1 instance
    logic        i_req1, i_rdy1, d_re1, d_we1, d_rdy1, mem_re1, mem_we1, busy1;
    logic [15:0] i_addr1, i_data1, d_addr1, d_wdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    unified_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_data(i_data),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdy(d_rdy), .d_rdata(d_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    unified_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdy(i_rdy1), .i_data(i_data1),
        .d_re(d_re1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdy(d_rdy1), .d_rdata(d_rdata1),
        .mem_re(mem_re1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data valid only in the 4th consecutive access cycle.
    int acc = 0;
    always @(posedge clk) begin
        if (mem_re | mem_we) acc <= acc + 1;
        else                 acc <= 0;
    end
    assign mem_rdata  = (mem_re && acc == 3) ?
                        ((mem_addr == 16'h0010) ? 16'hABCD : (mem_addr ^ 16'h5A5A)) : 16'hDEAD;
    assign mem_rdata1 = mem_re1 ? (mem_addr1 ^ 16'h1111) : 16'hDEAD;

    // Write log for the MEM_LAT=4 instance.
    int          wcnt = 0;
    logic [15:0] wlast_a = 16'h0;
    logic [15:0] wlast_d = 16'h0;
    always @(posedge clk) begin
        if (mem_we) begin
            wcnt    <= wcnt + 1;
            wlast_a <= mem_addr;
            wlast_d <= mem_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic        is_d;
        logic [15:0] data;
        logic [31:0] at;
    } exp_t;
    exp_t sb[$];

    task automatic push(input logic is_d, input logic [15:0] data, input int at);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every rdy pulse must match the oldest expectation in port, data and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mem_re | mem_we) check("mem_re_we_excl", {31'd0, mem_re & mem_we}, 32'd0);
        if (i_rdy | d_rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_rdy", {30'd0, i_rdy, d_rdy}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rdy_excl",  {31'd0, i_rdy & d_rdy}, 32'd0);
                check("rdy_port",  {31'd0, d_rdy}, {31'd0, e.is_d});
                check("rdy_data",  {16'd0, (e.is_d ? d_rdata : i_data)}, {16'd0, e.data});
                check("rdy_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        int t;
        int w0;
        rst = 1'b1;
        i_req = 0; i_addr = 0; d_re = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        i_req1 = 0; i_addr1 = 0; d_re1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
        tick(2);

        // Reset state
        check("rst_busy",      {31'd0, busy}, 0);
        check("rst_mem_re",    {31'd0, mem_re}, 0);
        check("rst_mem_we",    {31'd0, mem_we}, 0);
        check("rst_mem_addr",  {16'd0, mem_addr}, 0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 0);
        check("rst_rdy",       {30'd0, i_rdy, d_rdy}, 0);
        check("rst_i_data",    {16'd0, i_data}, 0);
        check("rst_d_rdata",   {16'd0, d_rdata}, 0);
        check("rst_busy1",     {31'd0, busy1}, 0);
        rst = 1'b0;
        tick(1);

        // Single fetch
        t = cyc;
        i_req = 1; i_addr = 16'h0010;
        push(1'b0, 16'hABCD, t + 5);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            check("t1_mem_re",   {31'd0, mem_re}, 1);
            check("t1_mem_we",   {31'd0, mem_we}, 0);
            check("t1_mem_addr", {16'd0, mem_addr}, 32'h0010);
            check("t1_busy",     {31'd0, busy}, 1);
        end
        tick(1);
        check("t1_resp_mem_re", {31'd0, mem_re}, 0);
        check("t1_resp_busy",   {31'd0, busy}, 1);
        i_req = 0;
        tick(2);
        check("t1_i_data_held", {16'd0, i_data}, 32'hABCD);
        check("t1_idle_busy",   {31'd0, busy}, 0);

        // Contention right after reset: data first, then fetch
        rst = 1; tick(1); rst = 0;
        t = cyc;
        i_req = 1; i_addr = 16'h0010; d_re = 1; d_addr = 16'h0020;
        push(1'b1, 16'h5A7A, t + 5);
        push(1'b0, 16'hABCD, t + 11);
        tick(1);
        check("t2_first_addr", {16'd0, mem_addr}, 32'h0020);
        tick(4);
        d_re = 0;
        tick(1);
        check("t2_gap_mem_re", {31'd0, mem_re}, 0);
        tick(1);
        check("t2_second_addr", {16'd0, mem_addr}, 32'h0010);
        check("t2_second_re",   {31'd0, mem_re}, 1);
        tick(4);
        i_req = 0;
        tick(1);

        // Store with read+write both set; bus changes after grant are ignored
        w0 = wcnt;
        t = cyc;
        d_re = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 16'h1234;
        push(1'b1, 16'h5A7A, t + 5);
        tick(1);
        d_addr = 16'h0099; d_wdata = 16'hFFFF;
        for (int k = 1; k <= 4; k++) begin
            check("t3_mem_we",    {31'd0, mem_we}, 1);
            check("t3_mem_re",    {31'd0, mem_re}, 0);
            check("t3_mem_addr",  {16'd0, mem_addr}, 32'h0040);
            check("t3_mem_wdata", {16'd0, mem_wdata}, 32'h1234);
            tick(1);
        end
        d_re = 0; d_we = 0;
        tick(1);
        check("t3_write_cycles", wcnt - w0, 4);
        check("t3_write_addr",   {16'd0, wlast_a}, 32'h0040);
        check("t3_write_data",   {16'd0, wlast_d}, 32'h1234);
        check("t3_d_rdata_held", {16'd0, d_rdata}, 32'h5A7A);

        // Sustained contention alternates D,I,D,I,D every 6 cycles
        rst = 1; tick(1); rst = 0;
        t = cyc;
        i_req = 1; i_addr = 16'h0010; d_re = 1; d_addr = 16'h0020;
        push(1'b1, 16'h5A7A, t + 5);
        push(1'b0, 16'hABCD, t + 11);
        push(1'b1, 16'h5A7A, t + 17);
        push(1'b0, 16'hABCD, t + 23);
        push(1'b1, 16'h5A7A, t + 29);
        tick(29);
        i_req = 0; d_re = 0;
        tick(2);
        check("t4_idle", {31'd0, busy}, 0);

        // Reset in the 2nd access cycle of a write
        t = cyc;
        d_we = 1; d_addr = 16'h0050; d_wdata = 16'h7777;
        tick(2);
        check("t5_pre_rst_we", {31'd0, mem_we}, 1);
        rst = 1;
        tick(1);
        check("t5_mem_we",    {31'd0, mem_we}, 0);
        check("t5_mem_re",    {31'd0, mem_re}, 0);
        check("t5_busy",      {31'd0, busy}, 0);
        check("t5_mem_addr",  {16'd0, mem_addr}, 0);
        check("t5_mem_wdata", {16'd0, mem_wdata}, 0);
        check("t5_d_rdata",   {16'd0, d_rdata}, 0);
        check("t5_i_data",    {16'd0, i_data}, 0);
        rst = 0; d_we = 0;
        tick(3);
        check("t5_no_retry", {31'd0, busy}, 0);

        // Fresh fetch whose request is dropped after grant still completes
        t = cyc;
        i_req = 1; i_addr = 16'h0010;
        push(1'b0, 16'hABCD, t + 5);
        tick(1);
        i_req = 0;
        tick(6);

        // Write dropped mid-access is still fully written
        w0 = wcnt;
        t = cyc;
        d_we = 1; d_addr = 16'h0060; d_wdata = 16'h4321;
        push(1'b1, 16'h0000, t + 5);
        tick(1);
        d_we = 0;
        tick(5);
        check("t5b_write_cycles", wcnt - w0, 4);
        check("t5b_write_data",   {16'd0, wlast_d}, 32'h4321);

        // MEM_LAT=1: one access cycle, d_rdy two cycles after sampling, twice in a row
        for (int r = 0; r < 2; r++) begin
            d_re1 = 1; d_addr1 = 16'h0007 + 16'(r);
            tick(1);
            check("t6_mem_re",   {31'd0, mem_re1}, 1);
            check("t6_mem_addr", {16'd0, mem_addr1}, 32'h0007 + r);
            check("t6_no_rdy",   {31'd0, d_rdy1}, 0);
            tick(1);
            check("t6_mem_re_off", {31'd0, mem_re1}, 0);
            check("t6_d_rdy",      {31'd0, d_rdy1}, 1);
            check("t6_d_rdata",    {16'd0, d_rdata1}, (32'h0007 + r) ^ 32'h1111);
            d_re1 = 0;
            tick(1);
            check("t6_rdy_pulse", {31'd0, d_rdy1}, 0);
            check("t6_idle",      {31'd0, busy1}, 0);
        end

        tick(2);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
